// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer for an external up/down counter: load lo, count up to hi,
// count back down to lo, optionally repeating; supports pause and abort.
module updown_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int SWEEP_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               continuous,
    input  logic [WIDTH-1:0]   lo_bound,
    input  logic [WIDTH-1:0]   hi_bound,
    input  logic [WIDTH-1:0]   cnt_val,
    output logic               cnt_load,
    output logic [WIDTH-1:0]   cnt_load_val,
    output logic               cnt_en,
    output logic               up_down,
    output logic               busy,
    output logic               sweep_done,
    output logic [SWEEP_W-1:0] sweep_cnt,
    output logic               cfg_err
);

    typedef enum logic [1:0] {IDLE, LOAD, UP, DOWN} state_t;

    state_t           state;
    logic [WIDTH-1:0] lo_q, hi_q;
    logic             at_hi, at_lo;

    // Inclusive compares so an out-of-range counter value turns around at once
    assign at_hi = (cnt_val >= hi_q);
    assign at_lo = (cnt_val <= lo_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lo_q       <= '0;
            hi_q       <= '0;
            sweep_cnt  <= '0;
            sweep_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            cfg_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        if (lo_bound >= hi_bound) begin
                            cfg_err <= 1'b1;
                        end else begin
                            lo_q      <= lo_bound;
                            hi_q      <= hi_bound;
                            sweep_cnt <= '0;
                            state     <= LOAD;
                        end
                    end
                end
                LOAD: state <= stop ? IDLE : UP;
                UP: begin
                    if (stop)
                        state <= IDLE;
                    else if (!pause && at_hi)
                        state <= DOWN;
                end
                DOWN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (!pause && at_lo) begin
                        sweep_done <= 1'b1;
                        if (sweep_cnt != '1)
                            sweep_cnt <= sweep_cnt + 1'b1;
                        state <= continuous ? UP : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cnt_load     = (state == LOAD) && !stop;
    assign cnt_load_val = (state == LOAD) ? lo_q : '0;
    assign up_down      = (state == UP);
    assign busy         = (state != IDLE);

    always_comb begin
        cnt_en = 1'b0;
        case (state)
            UP:      cnt_en = !pause && !stop && !at_hi;
            DOWN:    cnt_en = !pause && !stop && !at_lo;
            default: cnt_en = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Bench for updown_sweep_ctrl with a behavioural counter alongside and a
// queue of expected sweep_done cycles / sweep counts.
module tb_updown_sweep_ctrl;

    localparam int W  = 4;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          reset, start, stop, pause, continuous;
    logic [W-1:0]  lo_bound, hi_bound, cnt_val;
    logic          cnt_load, cnt_en, up_down, busy, sweep_done, cfg_err;
    logic [W-1:0]  cnt_load_val;
    logic [SW-1:0] sweep_cnt;

    updown_sweep_ctrl #(.WIDTH(W), .SWEEP_W(SW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .continuous(continuous), .lo_bound(lo_bound), .hi_bound(hi_bound),
        .cnt_val(cnt_val), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
        .cnt_en(cnt_en), .up_down(up_down), .busy(busy), .sweep_done(sweep_done),
        .sweep_cnt(sweep_cnt), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // The counter this block steers
    initial cnt_val = '0;
    always @(posedge clk) begin
        if (cnt_load)     cnt_val <= cnt_load_val;
        else if (cnt_en)  cnt_val <= up_down ? cnt_val + 1'b1 : cnt_val - 1'b1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    endtask

    typedef struct { int c; int s; } done_t;
    done_t done_q[$];
    done_t de;
    int    n_load = 0;

    function automatic void exp_done(input int c, input int s);
        done_t d;
        d.c = c;
        d.s = s;
        done_q.push_back(d);
    endfunction

    always @(negedge clk) begin
        if (cnt_load) n_load++;
        if (sweep_done) begin
            if (done_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                de = done_q.pop_front();
                chk("done_cyc", cyc, de.c);
                chk("done_scnt", int'(sweep_cnt), de.s);
            end
        end
    end

    int k;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int lo, input int hi, input bit cont);
        step();
        lo_bound   = W'(lo);
        hi_bound   = W'(hi);
        continuous = cont;
        start      = 1'b1;
        k          = cyc;
    endtask

    int exp_single[8] = '{2, 3, 4, 5, 5, 4, 3, 2};
    int base;

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; continuous = 1'b0;
        lo_bound = '0; hi_bound = '0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_load", int'(cnt_load), 0);
        chk("rst_load_val", int'(cnt_load_val), 0);
        chk("rst_en", int'(cnt_en), 0);
        chk("rst_updown", int'(up_down), 0);
        chk("rst_done", int'(sweep_done), 0);
        chk("rst_scnt", int'(sweep_cnt), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        step(); step();
        reset = 1'b1;

        // single sweep lo=2 hi=5
        launch(2, 5, 1'b0);
        exp_done(k + 10, 1);
        for (int rel = 1; rel <= 11; rel++) begin
            step();
            start = 1'b0;
            @(negedge clk);
            if (rel == 1) begin
                chk("single_load", int'(cnt_load), 1);
                chk("single_load_val", int'(cnt_load_val), 2);
                chk("single_load_en", int'(cnt_en), 0);
            end
            if (rel >= 1 && rel <= 9) chk("single_busy", int'(busy), 1);
            if (rel >= 2 && rel <= 9) begin
                chk("single_cnt", int'(cnt_val), exp_single[rel-2]);
                chk("single_dir", int'(up_down), (rel <= 5) ? 1 : 0);
            end
            if (rel >= 10) chk("single_idle", int'(busy), 0);
        end

        // rejected bounds: equal, then inverted
        for (int b = 0; b < 2; b++) begin
            step();
            lo_bound = (b == 0) ? W'(7) : W'(9);
            hi_bound = (b == 0) ? W'(7) : W'(3);
            start = 1'b1;
            step();
            start = 1'b0;
            @(negedge clk);
            chk("bad_cfg_err", int'(cfg_err), 1);
            chk("bad_busy", int'(busy), 0);
            chk("bad_load", int'(cnt_load), 0);
            step();
            @(negedge clk);
            chk("bad_cfg_err_pulse", int'(cfg_err), 0);
            chk("bad_busy2", int'(busy), 0);
        end

        // continuous 0..15, released after the third sweep
        base = n_load;
        launch(0, 15, 1'b1);
        for (int s = 0; s < 4; s++) exp_done(k + 34 + 32 * s, s + 1);
        for (int rel = 1; rel <= 131; rel++) begin
            step();
            start = 1'b0;
            if (rel == 100) continuous = 1'b0;
            @(negedge clk);
            if (rel == 66) begin
                chk("cont_wrap_cnt", int'(cnt_val), 0);
                chk("cont_wrap_dir", int'(up_down), 1);
            end
            if (rel == 129) chk("cont_busy_end", int'(busy), 1);
            if (rel >= 130) chk("cont_idle", int'(busy), 0);
        end
        chk("cont_no_reload", n_load - base, 1);

        // pause for 4 cycles while UP at 4
        launch(1, 6, 1'b0);
        exp_done(k + 18, 1);
        for (int rel = 1; rel <= 19; rel++) begin
            step();
            start = 1'b0;
            pause = (rel >= 5 && rel <= 8);
            @(negedge clk);
            if (rel >= 5 && rel <= 8) begin
                chk("pause_cnt", int'(cnt_val), 4);
                chk("pause_en", int'(cnt_en), 0);
                chk("pause_busy", int'(busy), 1);
            end
            if (rel == 9) chk("pause_resume_en", int'(cnt_en), 1);
            if (rel == 17) chk("pause_busy_end", int'(busy), 1);
            if (rel >= 18) chk("pause_idle", int'(busy), 0);
        end

        // start+stop together in IDLE is ignored
        step();
        lo_bound = W'(2); hi_bound = W'(5); start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("startstop_busy", int'(busy), 0);
        chk("startstop_load", int'(cnt_load), 0);
        chk("startstop_scnt_kept", int'(sweep_cnt), 1);

        // abort while DOWN at 3
        launch(2, 5, 1'b0);
        for (int rel = 1; rel <= 10; rel++) begin
            step();
            start = 1'b0;
            stop = (rel == 8);
            @(negedge clk);
            if (rel == 1) chk("restart_scnt_clr", int'(sweep_cnt), 0);
            if (rel == 8) begin
                chk("stop_cnt", int'(cnt_val), 3);
                chk("stop_dir", int'(up_down), 0);
                chk("stop_en", int'(cnt_en), 0);
                chk("stop_busy", int'(busy), 1);
            end
            if (rel >= 9) begin
                chk("stop_idle", int'(busy), 0);
                chk("stop_idle_en", int'(cnt_en), 0);
            end
        end

        // asynchronous reset mid-sweep
        launch(2, 5, 1'b0);
        for (int rel = 1; rel <= 4; rel++) begin
            step();
            start = 1'b0;
        end
        @(negedge clk);
        chk("pre_rst_dir", int'(up_down), 1);
        step();
        reset = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_load", int'(cnt_load), 0);
        chk("arst_en", int'(cnt_en), 0);
        chk("arst_dir", int'(up_down), 0);
        chk("arst_scnt", int'(sweep_cnt), 0);
        chk("arst_done", int'(sweep_done), 0);
        @(negedge clk);
        reset = 1'b1;

        launch(0, 1, 1'b0);
        exp_done(k + 6, 1);
        for (int rel = 1; rel <= 7; rel++) begin
            step();
            start = 1'b0;
            @(negedge clk);
            chk("post_rst_busy", int'(busy), (rel <= 5) ? 1 : 0);
        end

        step(); step(); step();
        chk("done_q_empty", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
